// File: rtl/pulse_burst_tx.sv
// pulse_burst_tx: emits a burst of single-cycle pulses on p_o, with a
// programmable idle gap between pulses, to drive a pulse detector. It counts
// the detector's r response over the burst and reports the count with a
// one-cycle done strobe.
module pulse_burst_tx #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             r_i,
  output logic             p_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] hits_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic [CNT_W-1:0] hits_reg, hits_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [GAP_W-1:0] gcnt_reg, gcnt_next;
  logic             counting;

  // State and datapath registers; reset may arrive at any time, including mid-burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      hits_reg  <= '0;
      gap_reg   <= '0;
      gcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      hits_reg  <= hits_next;
      gap_reg   <= gap_next;
      gcnt_reg  <= gcnt_next;
    end
  end

  // r_i is only meaningful while a burst (or its drain cycle) is in flight.
  assign counting = (state_reg == PULSE) || (state_reg == GAP) || (state_reg == DRAIN);

  // Next-state, counter and hit-accumulation logic.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    gap_next   = gap_reg;
    gcnt_next  = gcnt_reg;
    hits_next  = hits_reg;

    // Saturating hit counter; never wraps back to zero.
    if (counting && r_i && (hits_reg != HITS_MAX)) begin
      hits_next = hits_reg + CNT_W'(1);
    end

    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          hits_next = '0;
          if (len_i != '0) begin
            rem_next   = len_i;
            gap_next   = gap_i;
            state_next = PULSE;
          end else begin
            // Empty burst: report immediately with zero hits.
            state_next = DONE;
          end
        end
      end
      PULSE: begin
        rem_next = rem_reg - CNT_W'(1);
        if (rem_reg == CNT_W'(1)) begin
          state_next = DRAIN;
        end else if (gap_reg == '0) begin
          state_next = PULSE;
        end else begin
          gcnt_next  = gap_reg;
          state_next = GAP;
        end
      end
      GAP: begin
        // Counter holds the number of idle cycles still to go, this one included.
        gcnt_next = gcnt_reg - GAP_W'(1);
        if (gcnt_reg == GAP_W'(1)) begin
          state_next = PULSE;
        end
      end
      DRAIN: begin
        // Lets the detector's registered reply to the last pulse be counted.
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign p_o    = (state_reg == PULSE);
  assign busy_o = (state_reg != IDLE);
  assign done_o = (state_reg == DONE);
  assign hits_o = hits_reg;

endmodule

// File: tb/tb_pulse_burst_tx.sv
// Bench for pulse_burst_tx: a behavioural 3-pulse detector is looped back from
// p_o to r_i; expected pulse cycles and done/hits results are queued at
// stimulus time and checked by an independent monitor.
module tb_pulse_burst_tx;

  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] len_i = '0;
  logic [GAP_W-1:0] gap_i = '0;
  logic             r_i;
  logic             p_o, busy_o, done_o;
  logic [CNT_W-1:0] hits_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int pulse_q[$];
  int done_cyc_q[$];
  int done_hits_q[$];

  // Behavioural detector: A(0) -> B -> C -> D on pulses, D drops to A on p=0.
  logic [1:0] det_q = 2'd0;
  logic       det_rst = 1'b0;
  logic       force_r = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (det_rst) det_q <= 2'd0;
    else if (p_o) det_q <= (det_q == 2'd3) ? 2'd3 : det_q + 2'd1;
    else if (det_q == 2'd3) det_q <= 2'd0;
  end

  assign r_i = force_r | (det_q == 2'd3);

  pulse_burst_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .start_i(start_i),
    .len_i  (len_i),
    .gap_i  (gap_i),
    .r_i    (r_i),
    .p_o    (p_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .hits_o (hits_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every pulse and every done strobe with the queue heads.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (p_o) begin
        if (pulse_q.size() == 0) begin
          chk("unexpected_pulse", cyc, -1);
        end else begin
          chk("pulse_cycle", cyc, pulse_q.pop_front());
        end
      end
      if (done_o) begin
        if (done_cyc_q.size() == 0) begin
          chk("unexpected_done", cyc, -1);
        end else begin
          chk("done_cycle", cyc, done_cyc_q.pop_front());
          chk("done_hits", int'(hits_o), done_hits_q.pop_front());
          $display("burst done at cyc %0d hits=%0d", cyc, hits_o);
        end
      end
    end
  end

  task automatic reset_detector();
    @(negedge clk) det_rst = 1'b1;
    @(negedge clk) det_rst = 1'b0;
  endtask

  // Issue a start and queue the expected pulse cycles plus done cycle/hits.
  task automatic run_burst(input int len, input int gap, input int done_off,
                           input int hits_exp, input int extra_len);
    int s;
    @(negedge clk);
    s = cyc;
    start_i = 1'b1;
    len_i = CNT_W'(len);
    gap_i = GAP_W'(gap);
    for (int i = 0; i < len; i++) pulse_q.push_back(s + 1 + i * (gap + 1));
    done_cyc_q.push_back(s + done_off);
    done_hits_q.push_back(hits_exp);
    $display("start len=%0d gap=%0d at cyc %0d", len, gap, s);
    @(negedge clk);
    start_i = 1'b0;
    if (len == 0) begin
      chk("len0_busy_c1", int'(busy_o), 1);
      chk("len0_pulse_c1", int'(p_o), 0);
    end
    if (extra_len != 0) begin
      @(negedge clk);
      start_i = 1'b1;
      len_i = CNT_W'(extra_len);
      @(negedge clk);
      start_i = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (pulse_q.size() == 0 && done_cyc_q.size() == 0 && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("burst_timeout", 0, 1);
      pulse_q.delete();
      done_cyc_q.delete();
      done_hits_q.delete();
    end
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst_p", int'(p_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_hits", int'(hits_o), 0);
    rst_ni = 1'b1;
    reset_detector();

    // len=3 gap=0: pulses 1-3, done 5, hits 1.
    run_burst(3, 0, 5, 1, 0);
    wait_done(40);

    // len=6 gap=2: pulses 1,4,...,16, done 18, hits 2.
    reset_detector();
    run_burst(6, 2, 18, 2, 0);
    wait_done(60);

    // len=0: done on cycle 1, busy one cycle only, no pulses.
    run_burst(0, 3, 1, 0, 0);
    @(negedge clk);
    chk("len0_busy_c2", int'(busy_o), 0);
    wait_done(10);

    // len=4 gap=1 with a second start (len=9) at cycle 2: ignored.
    reset_detector();
    run_burst(4, 1, 9, 1, 9);
    wait_done(60);

    // Forced r_i, len=15 gap=1: hits saturate at 15 instead of wrapping to 14.
    force_r = 1'b1;
    run_burst(15, 1, 31, 15, 0);
    wait_done(80);

    // Reset during the GAP of a len=5 burst with r forced high.
    @(negedge clk);
    s = cyc;
    start_i = 1'b1;
    len_i = CNT_W'(5);
    gap_i = GAP_W'(3);
    pulse_q.push_back(s + 1);
    $display("start len=5 gap=3 at cyc %0d (reset mid-burst)", s);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("gap_busy", int'(busy_o), 1);
    chk("gap_hits", int'(hits_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_p", int'(p_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_done", int'(done_o), 0);
    chk("midrst_hits", int'(hits_o), 0);
    force_r = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("post_rst_busy", int'(busy_o), 0);
    chk("post_rst_hits", int'(hits_o), 0);
    chk("pulse_q_empty", pulse_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
